id_exe_skid_stage: RTL
======================

Name: id_exe_skid_stage

Overview:
- Parametrised successor to the fixed ID/EXE pipeline register.
- Elastic 2-entry stage (main + skid) between decode and execute, with valid/ready handshake on both sides.
- Synchronous flush that kills held instructions.
- Write-back forwarding into held operands, so a stalled instruction never carries stale rs1/rs2 data.

Parameters:
XLEN, 32, width of pc, operand data and immediate
REG_AW, 5, register address width
CTRL_W, 16, width of packed control bundle (ALUOP, MemRead, MemWrite, RegWrite, branch, csrweb, ...)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  decode has an instruction
in_ready  out  1  stage can accept; equals !skid_valid (registered, no combinational path from out_ready)
in_pc / in_rs1data / in_rs2data / in_imm  in  XLEN each  decode payload
in_rs1addr / in_rs2addr / in_rdaddr  in  REG_AW each  register addresses
in_ctrl  in  CTRL_W  control bundle
flush  in  1  kill all held and incoming instructions
wb_we  in  1  write-back register write
wb_rdaddr  in  REG_AW  write-back destination
wb_rddata  in  XLEN  write-back data
out_valid  out  1  main entry valid
out_ready  in  1  execute accepts
out_pc / out_rs1data / out_rs2data / out_imm  out  XLEN  main entry payload
out_rs1addr / out_rs2addr / out_rdaddr  out  REG_AW  main entry addresses
out_ctrl  out  CTRL_W  main entry control; zero whenever out_valid=0
occupancy  out  2  number of valid entries (0..2)

Behaviour:
- Reset (rst=0, asynchronous): all outputs and both entries zero; out_valid=0; occupancy=0; in_ready=1.
- Fire events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput: 1 instruction per cycle.
- States (occupancy):
  - EMPTY:
    - in_fire -> main<=in; ONE.
  - ONE:
    - in_fire & out_fire -> main<=in; ONE.
    - in_fire only -> skid<=in; FULL.
    - out_fire only -> EMPTY.
    - Neither -> hold.
  - FULL (in_ready=0):
    - out_fire -> main<=skid; ONE.
    - Otherwise hold.
- Ordering: skid always holds the younger instruction; output order equals input order.
- Flush (synchronous, priority over everything except reset):
  - Next state EMPTY; both valid bits cleared; out_ctrl zeroed.
  - Any same-cycle in_fire is discarded.
  - A same-cycle out_fire still counts as consumed by execute.
- Write-back forwarding, each cycle for every valid entry:
  - If wb_we and wb_rdaddr!=0 and wb_rdaddr==entry.rs1addr: entry.rs1data<=wb_rddata. Same rule for rs2.
- Forwarding also applies on load:
  - Applies to in_* loaded into main/skid, and to skid->main transfer.
  - The captured value is the forwarded one.
- x0 is never forwarded. rs1addr==rs2addr==wb_rdaddr updates both operands.
- Flush and forwarding in the same cycle: flush wins; entry data is don't-care once invalid.

Optional Feature:
- Macro ID_EXE_SKID_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt counts cycles with in_valid & !in_ready.
  - perf_flush_cnt counts cycles where flush=1 and occupancy!=0.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package id_exe_pkg:
  - typedef struct packed id_payload_t (pc, rs1addr, rs2addr, rs1data, rs2data, imm, rdaddr, ctrl).
  - Occupancy localparams EMPTY/ONE/FULL.
  - fwd_match function (wb_we, wb_rdaddr, addr).
- One sub-module, id_exe_entry:
  - A single payload register with valid bit, load mux and WB forwarding.
  - Instantiated twice (main, skid).

Test Plan:
- Reset mid-FULL: fill both entries, drop rst -> out_valid=0, occupancy=0, in_ready=1 immediately; out_ctrl=0.
- Streaming: in_valid=1 every cycle, out_ready=1, pc 0x00,0x04,0x08 -> out_pc same sequence one cycle later, occupancy stays 1.
- Backpressure: out_ready=0 for 3 cycles while sending pc 0x10,0x14,0x18 -> occupancy 2, in_ready=0, 0x18 held at input; out_ready=1 -> outputs 0x10,0x14,0x18 in order.
- Stall forwarding: main holds rs1addr=5, rs1data=0x1111, out_ready=0; wb_we=1, wb_rdaddr=5, wb_rddata=0xABCD -> next cycle out_rs1data=0xABCD. Repeat with wb_rdaddr=0 -> unchanged.
- Flush with concurrent input: occupancy 2, flush=1, in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy 0; flushed input never appears.
- Perf (macro on): 4 stall cycles then 1 flush of a non-empty stage -> perf_stall_cnt=4, perf_flush_cnt=1.

Source files
------------

// File: rtl/id_exe_pkg.sv
// Shared types and helpers for the ID/EXE elastic stage: occupancy encoding,
// default-width payload layout and the write-back forwarding match.
package id_exe_pkg;

  localparam int ID_XLEN   = 32;
  localparam int ID_REG_AW = 5;
  localparam int ID_CTRL_W = 16;

  // Register addresses are compared at this width; REG_AW must not exceed it.
  localparam int ID_AW_MAX = 8;

  // Stage occupancy doubles as the FSM state encoding.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic [ID_XLEN-1:0]   pc;
    logic [ID_REG_AW-1:0] rs1addr;
    logic [ID_REG_AW-1:0] rs2addr;
    logic [ID_XLEN-1:0]   rs1data;
    logic [ID_XLEN-1:0]   rs2data;
    logic [ID_XLEN-1:0]   imm;
    logic [ID_REG_AW-1:0] rdaddr;
    logic [ID_CTRL_W-1:0] ctrl;
  } id_payload_t;

  // x0 is hard-wired zero, so a write to it never forwards.
  function automatic logic fwd_match(input logic                 wb_we,
                                     input logic [ID_AW_MAX-1:0] wb_rdaddr,
                                     input logic [ID_AW_MAX-1:0] addr);
    return wb_we && (wb_rdaddr != '0) && (wb_rdaddr == addr);
  endfunction

endpackage

// File: rtl/id_exe_entry.sv
// One payload register with valid bit; the operand data is refreshed from
// write-back both while held and on the cycle it is loaded.
module id_exe_entry
  import id_exe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16,
  localparam int PW    = 4*XLEN + 3*REG_AW + CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drop,
  input  logic [PW-1:0]     d,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rdaddr,
  input  logic [XLEN-1:0]   wb_rddata,
  output logic              valid,
  output logic [PW-1:0]     q
);

  // Field order must stay identical to the top-level payload layout.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1addr;
    logic [REG_AW-1:0] rs2addr;
    logic [XLEN-1:0]   rs1data;
    logic [XLEN-1:0]   rs2data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rdaddr;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  payload_t d_s;
  payload_t q_s;
  payload_t src;
  payload_t nxt;

  assign d_s = d;
  assign q   = q_s;

  always_comb begin
    src = load ? d_s : q_s;
    nxt = src;
    if (fwd_match(wb_we, ID_AW_MAX'(wb_rdaddr), ID_AW_MAX'(src.rs1addr)))
      nxt.rs1data = wb_rddata;
    if (fwd_match(wb_we, ID_AW_MAX'(wb_rdaddr), ID_AW_MAX'(src.rs2addr)))
      nxt.rs2data = wb_rddata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q_s   <= '0;
    end else begin
      if (load)
        valid <= 1'b1;
      else if (drop)
        valid <= 1'b0;
      q_s <= nxt;
    end
  end

endmodule

// File: rtl/id_exe_skid_stage.sv
// Elastic two-entry ID/EXE stage (main + skid) with flush and write-back
// forwarding. Define ID_EXE_SKID_PERF_EN to add stall/flush counters.
module id_exe_skid_stage
  import id_exe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1data,
  input  logic [XLEN-1:0]   in_rs2data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rs1addr,
  input  logic [REG_AW-1:0] in_rs2addr,
  input  logic [REG_AW-1:0] in_rdaddr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rdaddr,
  input  logic [XLEN-1:0]   wb_rddata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1data,
  output logic [XLEN-1:0]   out_rs2data,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_rs1addr,
  output logic [REG_AW-1:0] out_rs2addr,
  output logic [REG_AW-1:0] out_rdaddr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef ID_EXE_SKID_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1addr;
    logic [REG_AW-1:0] rs2addr;
    logic [XLEN-1:0]   rs1data;
    logic [XLEN-1:0]   rs2data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rdaddr;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       in_fire;
  logic       out_fire;
  logic       main_load;
  logic       main_from_skid;
  logic       main_drop;
  logic       skid_load;
  logic       skid_drop;
  logic       main_valid;
  logic       skid_valid;
  payload_t   in_p;
  payload_t   main_d;
  payload_t   main_q;
  payload_t   skid_q;

  // Handshake: a transfer occurs on a rising edge where valid and ready are
  // both high; in_ready is purely registered (no path from out_ready), and a
  // held instruction stays on the out_* bus until it transfers or is flushed.
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

  assign in_p.pc      = in_pc;
  assign in_p.rs1addr = in_rs1addr;
  assign in_p.rs2addr = in_rs2addr;
  assign in_p.rs1data = in_rs1data;
  assign in_p.rs2data = in_rs2data;
  assign in_p.imm     = in_imm;
  assign in_p.rdaddr  = in_rdaddr;
  assign in_p.ctrl    = in_ctrl;

  assign main_d = main_from_skid ? skid_q : in_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  // Flush beats everything: incoming data is discarded, held entries die.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      main_drop = 1'b1;
      skid_drop = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            main_drop = 1'b1;
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_drop = 1'b1;
          skid_drop = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    occupancy   = state;
    out_valid   = main_valid;
    out_pc      = main_q.pc;
    out_rs1addr = main_q.rs1addr;
    out_rs2addr = main_q.rs2addr;
    out_rs1data = main_q.rs1data;
    out_rs2data = main_q.rs2data;
    out_imm     = main_q.imm;
    out_rdaddr  = main_q.rdaddr;
    out_ctrl    = main_valid ? main_q.ctrl : '0;
  end

  id_exe_entry #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .drop      (main_drop),
    .d         (main_d),
    .wb_we     (wb_we),
    .wb_rdaddr (wb_rdaddr),
    .wb_rddata (wb_rddata),
    .valid     (main_valid),
    .q         (main_q)
  );

  // Skid only ever takes the younger instruction straight from decode.
  id_exe_entry #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .drop      (skid_drop),
    .d         (in_p),
    .wb_we     (wb_we),
    .wb_rdaddr (wb_rdaddr),
    .wb_rddata (wb_rddata),
    .valid     (skid_valid),
    .q         (skid_q)
  );

`ifdef ID_EXE_SKID_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && (state != EMPTY) && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
